// File: rtl/spi_resp_pkg.sv
// Shared constants and types for the ADXL362 SPI responder: command
// opcodes, ID register contents and the transaction state encoding.
package spi_resp_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    localparam logic [7:0] ID_DEVID_AD  = 8'hAD;
    localparam logic [7:0] ID_DEVID_MST = 8'h1D;
    localparam logic [7:0] ID_PARTID    = 8'hF2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMD    = 3'd1,
        ADDR   = 3'd2,
        WDATA  = 3'd3,
        RDATA  = 3'd4,
        IGNORE = 3'd5
    } state_t;

    // Power-on contents of the register file (ID bytes at 0..2, zero elsewhere).
    function automatic logic [7:0] reg_reset_value(input int idx);
        case (idx)
            0:       reg_reset_value = ID_DEVID_AD;
            1:       reg_reset_value = ID_DEVID_MST;
            2:       reg_reset_value = ID_PARTID;
            default: reg_reset_value = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_resp_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, with single-clk
// rise/fall pulses derived from the synchronized level.
module spi_resp_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Metastability pair followed by a delay flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_adxl362_responder.sv
// SPI mode-0 responder emulating the ADXL362 register interface
// (0x0A write / 0x0B read, address byte, then data bytes), with a
// system-side port for preloading and observing the register file.
// Build option: define SPI_RESP_BURST_EN to let the pointer auto-increment
// across multi-byte bursts; without it only the first data byte is handled.
module spi_adxl362_responder
    import spi_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int RO_REGS    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  busy,
    output logic                  wr_strobe,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]            wr_data,
    input  logic                  sys_we,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic [7:0]            sys_wdata,
    output logic [7:0]            sys_rdata
);

    localparam int                    DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] RO_LIM = ADDR_WIDTH'(RO_REGS);
    localparam logic [ADDR_WIDTH-1:0] ONE    = ADDR_WIDTH'(1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync,   w_cs_rise,   w_cs_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    state_t                r_state;
    logic [2:0]            r_bit_cnt;
    logic                  r_op_wr;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic                  r_miso;
    logic [1:0]            r_warm;
    logic [7:0]            r_rx_shift;
    logic [7:0]            r_tx_shift;
    logic [7:0]            r_regs [DEPTH];
    logic                  r_wr_strobe;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;

    logic [7:0] w_rx_byte;
    logic [7:0] w_rd_byte;
    logic       w_byte_done;
    logic       w_spi_we;
    logic       w_tx_step;

    spi_resp_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .i_async(sclk),
        .o_sync (w_sclk_sync),
        .o_rise (w_sclk_rise),
        .o_fall (w_sclk_fall)
    );

    // cs_n idles high, so its synchronizer resets to the deselected level.
    spi_resp_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
        .clk    (clk),
        .rst    (rst),
        .i_async(cs_n),
        .o_sync (w_cs_sync),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    spi_resp_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk    (clk),
        .rst    (rst),
        .i_async(mosi),
        .o_sync (w_mosi_sync),
        .o_rise (w_mosi_rise),
        .o_fall (w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_sync, w_cs_rise, w_mosi_rise, w_mosi_fall};

    // mosi and sclk share the same synchronizer latency, so the sampled
    // bit is aligned with the detected rising edge.
    assign w_rx_byte   = {r_rx_shift[6:0], w_mosi_sync};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_rd_byte   = r_regs[r_ptr];
    assign w_spi_we    = !w_cs_sync && (r_state == WDATA) && w_byte_done &&
                         (r_ptr >= RO_LIM);
    assign w_tx_step   = !w_cs_sync && (r_state == RDATA) && w_sclk_fall;

    // Transaction FSM: command/address decode, pointer, bit count and miso.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_op_wr   <= 1'b0;
            r_ptr     <= '0;
            r_miso    <= 1'b0;
            r_warm    <= 2'd0;
        end else begin
            // A cs_n fall is trusted only once the synchronizer and edge
            // flop hold real samples; this keeps a reset taken mid-frame
            // from starting CMD partway through a byte.
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            if (w_cs_sync) begin
                r_state   <= IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else begin
                if (w_sclk_rise && (r_state != IDLE)) begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                case (r_state)
                    IDLE: begin
                        if (w_cs_fall && (r_warm == 2'd3)) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    CMD: begin
                        if (w_byte_done) begin
                            if (w_rx_byte == CMD_WRITE) begin
                                r_state <= ADDR;
                                r_op_wr <= 1'b1;
                            end else if (w_rx_byte == CMD_READ) begin
                                r_state <= ADDR;
                                r_op_wr <= 1'b0;
                            end else begin
                                r_state <= IGNORE;
                            end
                        end
                    end
                    ADDR: begin
                        if (w_byte_done) begin
                            r_ptr   <= w_rx_byte[ADDR_WIDTH-1:0];
                            r_state <= r_op_wr ? WDATA : RDATA;
                        end
                    end
                    WDATA: begin
                        if (w_byte_done) begin
                            r_ptr <= r_ptr + ONE;
`ifndef SPI_RESP_BURST_EN
                            r_state <= IGNORE;
`endif
                        end
                    end
                    RDATA: begin
                        if (w_sclk_fall) begin
                            if (r_bit_cnt == 3'd0) begin
                                r_miso <= w_rd_byte[7];
                                r_ptr  <= r_ptr + ONE;
                            end else begin
                                r_miso <= r_tx_shift[6];
                            end
                        end
`ifndef SPI_RESP_BURST_EN
                        if (w_byte_done) begin
                            r_state <= IGNORE;
                            r_miso  <= 1'b0;
                        end
`endif
                    end
                    IGNORE: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Shift registers carry data only; their contents are always fully
    // overwritten before use, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_sclk_rise) begin
            r_rx_shift <= w_rx_byte;
        end
        if (w_tx_step) begin
            r_tx_shift <= (r_bit_cnt == 3'd0) ? w_rd_byte : {r_tx_shift[6:0], 1'b0};
        end
    end

    // Register file: system writes first, an SPI commit to the same
    // address in the same cycle overrides it; ID registers are read-only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= reg_reset_value(i);
            end
        end else begin
            if (sys_we && (sys_addr >= RO_LIM)) begin
                r_regs[sys_addr] <= sys_wdata;
            end
            if (w_spi_we) begin
                r_regs[r_ptr] <= w_rx_byte;
            end
        end
    end

    // Committed-write report, visible the clock after the commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
        end else begin
            r_wr_strobe <= w_spi_we;
            if (w_spi_we) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_rx_byte;
            end
        end
    end

    assign miso      = r_miso;
    assign busy      = ~w_cs_sync;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign sys_rdata = r_regs[sys_addr];

endmodule

// File: tb/tb_spi_adxl362_responder.sv
// Scoreboard bench for spi_adxl362_responder: stimulus pushes expected
// write strobes, miso bytes and sys_rdata values; monitors pop and compare.
module tb_spi_adxl362_responder;

    localparam int HALF = 500;   // SCLK half period = 50 clk periods

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       sys_we = 1'b0;
    logic [5:0] sys_addr = 6'd0;
    logic [7:0] sys_wdata = 8'd0;
    logic       miso;
    logic       busy;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] sys_rdata;

    spi_adxl362_responder #(.ADDR_WIDTH(6), .RO_REGS(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .cs_n     (cs_n),
        .mosi     (mosi),
        .miso     (miso),
        .busy     (busy),
        .wr_strobe(wr_strobe),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .sys_we   (sys_we),
        .sys_addr (sys_addr),
        .sys_wdata(sys_wdata),
        .sys_rdata(sys_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    int         total = 0;
    int         bad = 0;
    wr_t        exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_sys_q[$];
    logic [7:0] rx_byte;
    wr_t        mon_e;
    logic [7:0] mon_b;
    event       rx_ev;
    event       sys_ev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Write-strobe monitor
    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_strobe_unexpected: got addr %0h data %0h, expected no strobe",
                         wr_addr, wr_data);
            end else begin
                mon_e = exp_wr_q.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                chk("wr_data", 32'(wr_data), 32'(mon_e.d));
            end
        end
    end

    // miso byte monitor
    always @(rx_ev) begin
        if (exp_rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL miso_unexpected: got %0h, expected nothing queued", rx_byte);
        end else begin
            mon_b = exp_rd_q.pop_front();
            chk("miso_byte", 32'(rx_byte), 32'(mon_b));
        end
    end

    // sys_rdata monitor
    always @(sys_ev) begin
        if (exp_sys_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sys_unexpected: got %0h, expected nothing queued", sys_rdata);
        end else begin
            mon_b = exp_sys_q.pop_front();
            chk("sys_rdata", 32'(sys_rdata), 32'(mon_b));
        end
    end

    task automatic spi_byte(input logic [7:0] b, input int nbits,
                            input bit chk_rx, input logic [7:0] exp);
        logic [7:0] r;
        r = 8'h00;
        if (chk_rx) exp_rd_q.push_back(exp);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            #(HALF);
            sclk = 1'b1;
            r = {r[6:0], miso};
            #(HALF);
            sclk = 1'b0;
        end
        if (chk_rx) begin
            rx_byte = r;
            ->rx_ev;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_end();
        #(HALF);
        cs_n = 1'b1;
        repeat (10) @(posedge clk);
    endtask

    task automatic spi_read(input logic [7:0] a, input int n,
                            input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        cs_begin();
        spi_byte(8'h0B, 8, 1'b0, 8'h00);
        spi_byte(a, 8, 1'b0, 8'h00);
        if (n > 0) spi_byte(8'h00, 8, 1'b1, e0);
        if (n > 1) spi_byte(8'h00, 8, 1'b1, e1);
        if (n > 2) spi_byte(8'h00, 8, 1'b1, e2);
        cs_end();
    endtask

    task automatic spi_write(input logic [7:0] a, input int n,
                             input logic [7:0] d0, input logic [7:0] d1);
        cs_begin();
        spi_byte(8'h0A, 8, 1'b0, 8'h00);
        spi_byte(a, 8, 1'b0, 8'h00);
        if (n > 0) spi_byte(d0, 8, 1'b0, 8'h00);
        if (n > 1) spi_byte(d1, 8, 1'b0, 8'h00);
        cs_end();
    endtask

    task automatic sys_write(input logic [5:0] a, input logic [7:0] d);
        @(negedge clk);
        sys_addr  = a;
        sys_wdata = d;
        sys_we    = 1'b1;
        @(negedge clk);
        sys_we    = 1'b0;
    endtask

    task automatic sys_check(input logic [5:0] a, input logic [7:0] exp);
        @(negedge clk);
        exp_sys_q.push_back(exp);
        sys_addr = a;
        #2;
        ->sys_ev;
    endtask

    // Watchdog
    initial begin
        #(10_000_000);
        total++;
        bad++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_wr_data", 32'(wr_data), 32'd0);
        sys_check(6'd0, 8'hAD);
        sys_check(6'd1, 8'h1D);
        sys_check(6'd2, 8'hF2);
        sys_check(6'd5, 8'h00);

        // ID read burst from address 0
`ifdef SPI_RESP_BURST_EN
        spi_read(8'h00, 3, 8'hAD, 8'h1D, 8'hF2);
`else
        spi_read(8'h00, 3, 8'hAD, 8'h00, 8'h00);
`endif

        // Single write, then readback through both ports
        exp_wr_q.push_back('{a: 6'h2D, d: 8'h02});
        spi_write(8'h2D, 1, 8'h02, 8'h00);
        sys_check(6'h2D, 8'h02);
        spi_read(8'h2D, 1, 8'h02, 8'h00, 8'h00);

        // System preload then SPI burst read
        sys_write(6'h08, 8'h12);
        sys_write(6'h09, 8'h34);
        sys_write(6'h0A, 8'h56);
`ifdef SPI_RESP_BURST_EN
        spi_read(8'h08, 3, 8'h12, 8'h34, 8'h56);
`else
        spi_read(8'h08, 3, 8'h12, 8'h00, 8'h00);
`endif

        // Writes to read-only registers are dropped
        spi_write(8'h00, 1, 8'h55, 8'h00);
        sys_check(6'd0, 8'hAD);
        sys_write(6'd1, 8'h99);
        sys_check(6'd1, 8'h1D);

        // Invalid command: miso stays low, no strobe
        cs_begin();
        spi_byte(8'h0C, 8, 1'b0, 8'h00);
        spi_byte(8'hFF, 8, 1'b1, 8'h00);
        spi_byte(8'hFF, 8, 1'b1, 8'h00);
        cs_end();

        // Abort after 4 data bits
        cs_begin();
        spi_byte(8'h0A, 8, 1'b0, 8'h00);
        spi_byte(8'h20, 8, 1'b0, 8'h00);
        spi_byte(8'hC3, 4, 1'b0, 8'h00);
        @(negedge clk);
        chk("busy_mid_frame", 32'(busy), 32'd1);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_after_abort", 32'(busy), 32'd0);
        repeat (10) @(posedge clk);
        sys_check(6'h20, 8'h00);
        exp_wr_q.push_back('{a: 6'h20, d: 8'h3C});
        spi_write(8'h20, 1, 8'h3C, 8'h00);
        sys_check(6'h20, 8'h3C);

        // Burst write across the top of the address space
        exp_wr_q.push_back('{a: 6'h3F, d: 8'hAA});
        spi_write(8'h3F, 2, 8'hAA, 8'hBB);
        sys_check(6'h3F, 8'hAA);
        sys_check(6'h00, 8'hAD);

        // Reset mid-frame: remaining bytes with cs_n still low are ignored
        cs_begin();
        spi_byte(8'h0A, 4, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        spi_byte(8'h0A, 8, 1'b0, 8'h00);
        spi_byte(8'h30, 8, 1'b0, 8'h00);
        spi_byte(8'h77, 8, 1'b0, 8'h00);
        cs_end();
        sys_check(6'h30, 8'h00);
        sys_check(6'h2D, 8'h00);
        sys_check(6'h20, 8'h00);
        exp_wr_q.push_back('{a: 6'h31, d: 8'h5A});
        spi_write(8'h31, 1, 8'h5A, 8'h00);
        sys_check(6'h31, 8'h5A);

        // Every queued expectation must have been consumed
        repeat (20) @(posedge clk);
        chk("wr_queue_left", 32'(exp_wr_q.size()), 32'd0);
        chk("rd_queue_left", 32'(exp_rd_q.size()), 32'd0);
        chk("sys_queue_left", 32'(exp_sys_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
